// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and digit limits for the stopwatch time core.
//                bcd_t is one BCD digit. state_t is the IDLE/RUN/PAUSED
//                control state.
//  Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam bcd_t SEC_LO_MAX = 4'd9;
    localparam bcd_t SEC_HI_MAX = 4'd5;
    localparam bcd_t MIN_LO_MAX = 4'd9;
    localparam bcd_t MIN_HI_MAX = 4'd5;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_step
//  Description : Combinational single-digit add/subtract with carry/borrow.
//                The digit counts modulo (i_max+1).
//                Ports: i_digit  current digit (0..i_max)
//                       i_amount value to add/subtract (0..9)
//                       i_max    largest legal digit value
//                       i_down   0 = add, 1 = subtract
//                       i_carry  carry/borrow from the lower digit
//                       o_digit  resulting digit
//                       o_carry  carry/borrow to the higher digit
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_step
    import stopwatch_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic [3:0] i_amount,
    input  logic [3:0] i_max,
    input  logic       i_down,
    input  logic       i_carry,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    logic [4:0] w_sum;
    logic [4:0] w_need;

    always_comb begin
        w_sum   = {1'b0, i_digit} + {1'b0, i_amount} + {4'd0, i_carry};
        w_need  = {1'b0, i_amount} + {4'd0, i_carry};
        o_digit = i_digit;
        o_carry = 1'b0;
        if (i_down) begin
            // A borrow adds one full digit period (i_max+1). The sum is at most 19,
            // so one adjustment is always enough.
            if ({1'b0, i_digit} < w_need) begin
                o_digit = 4'({1'b0, i_digit} + {1'b0, i_max} + 5'd1 - w_need);
                o_carry = 1'b1;
            end else begin
                o_digit = 4'({1'b0, i_digit} - w_need);
            end
        end else begin
            if (w_sum > {1'b0, i_max}) begin
                o_digit = 4'(w_sum - {1'b0, i_max} - 5'd1);
                o_carry = 1'b1;
            end else begin
                o_digit = 4'(w_sum);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_time_core.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_time_core
//  Description : Holds the MM:SS value as four BCD digits. Runs the
//                IDLE/RUN/PAUSED control machine and a cycle prescaler. Every
//                TICK_DIV RUN cycles it steps the value by STEP seconds, up or
//                down.
//                Inputs : clk, rst (sync, active high), start, stop, clear,
//                         dir_down, load, load_val[15:0] {mh,ml,sh,sl}
//                Outputs: sec_lo, sec_hi, min_lo, min_hi, running, tick,
//                         wrap, done, load_err (all registered)
//  Revision    : 1.0  initial release
// ============================================================================
module stopwatch_time_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100,
    parameter int STEP     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        dir_down,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  sec_lo,
    output logic [3:0]  sec_hi,
    output logic [3:0]  min_lo,
    output logic [3:0]  min_hi,
    output logic        running,
    output logic        tick,
    output logic        wrap,
    output logic        done,
    output logic        load_err
);

    localparam int                c_pres_w = $clog2(TICK_DIV);
    localparam logic [c_pres_w-1:0] c_last = c_pres_w'(TICK_DIV - 1);
    localparam bcd_t              c_step   = bcd_t'(STEP);

    state_t              r_state;
    logic [c_pres_w-1:0] r_pres;
    bcd_t                r_digit [4];   // index 0 = sec_lo ... 3 = min_hi
    logic                r_running, r_tick, r_wrap, r_done, r_load_err;

    bcd_t w_max  [4];
    bcd_t w_amt  [4];
    bcd_t w_next [4];
    logic w_c    [5];
    logic w_load_ok;
    logic w_reach_zero;

    assign w_max[0] = SEC_LO_MAX;
    assign w_max[1] = SEC_HI_MAX;
    assign w_max[2] = MIN_LO_MAX;
    assign w_max[3] = MIN_HI_MAX;
    assign w_amt[0] = c_step;
    assign w_amt[1] = 4'd0;
    assign w_amt[2] = 4'd0;
    assign w_amt[3] = 4'd0;
    assign w_c[0]   = 1'b0;

    // Ripple chain: sec_lo takes STEP. The higher digits only take carry/borrow.
    for (genvar gi = 0; gi < 4; gi++) begin : g_step
        bcd_digit_step u_step (
            .i_digit  (r_digit[gi]),
            .i_amount (w_amt[gi]),
            .i_max    (w_max[gi]),
            .i_down   (dir_down),
            .i_carry  (w_c[gi]),
            .o_digit  (w_next[gi]),
            .o_carry  (w_c[gi+1])
        );
    end

    assign w_load_ok = (load_val[3:0]   <= SEC_LO_MAX) && (load_val[7:4]   <= SEC_HI_MAX) &&
                       (load_val[11:8]  <= MIN_LO_MAX) && (load_val[15:12] <= MIN_HI_MAX);

    // A borrow out of min_hi means total < STEP. An all-zero result means
    // total == STEP. In both cases the count-down has finished.
    assign w_reach_zero = w_c[4] ||
                          ((w_next[0] == 4'd0) && (w_next[1] == 4'd0) &&
                           (w_next[2] == 4'd0) && (w_next[3] == 4'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pres     <= '0;
            r_digit    <= '{default: 4'd0};
            r_running  <= 1'b0;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
            r_done     <= 1'b0;
            r_load_err <= 1'b0;
            if (clear) begin
                r_state   <= IDLE;
                r_running <= 1'b0;
                r_pres    <= '0;
                r_digit   <= '{default: 4'd0};
            end else if (load) begin
                // A load request occupies the whole cycle, even when it is
                // rejected. The prescaler does not advance on that cycle.
                if ((r_state != RUN) && w_load_ok) begin
                    r_digit[0] <= load_val[3:0];
                    r_digit[1] <= load_val[7:4];
                    r_digit[2] <= load_val[11:8];
                    r_digit[3] <= load_val[15:12];
                    r_pres     <= '0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else begin
                case (r_state)
                    RUN: begin
                        if (stop) begin
                            r_state   <= PAUSED;
                            r_running <= 1'b0;
                        end else if (r_pres == c_last) begin
                            r_pres <= '0;
                            r_tick <= 1'b1;
                            if (dir_down && w_reach_zero) begin
                                r_digit   <= '{default: 4'd0};
                                r_done    <= 1'b1;
                                r_state   <= IDLE;
                                r_running <= 1'b0;
                            end else begin
                                r_digit <= w_next;
                                r_wrap  <= !dir_down && w_c[4];
                            end
                        end else begin
                            r_pres <= r_pres + 1'b1;
                        end
                    end
                    IDLE, PAUSED: begin
                        if (start && !stop) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sec_lo   = r_digit[0];
    assign sec_hi   = r_digit[1];
    assign min_lo   = r_digit[2];
    assign min_hi   = r_digit[3];
    assign running  = r_running;
    assign tick     = r_tick;
    assign wrap     = r_wrap;
    assign done     = r_done;
    assign load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_time_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_time_core
//  Description : Self-checking bench. Two cores (STEP=1 and STEP=2,
//                TICK_DIV=4) share one input stream. Each is compared every
//                cycle against a model that keeps the time as total seconds.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_stopwatch_time_core;

    localparam int c_div = 4;

    logic        clk;
    logic        rst, start, stop, clear, dir_down, load;
    logic [15:0] load_val;

    logic [3:0] sl1, sh1, ml1, mh1, sl2, sh2, ml2, mh2;
    logic       run1, tick1, wrap1, done1, lerr1;
    logic       run2, tick2, wrap2, done2, lerr2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        int secs;
        int st;      // 0 idle, 1 run, 2 paused
        int pres;
        bit tick;
        bit wrap;
        bit done;
        bit lerr;
    } mdl_t;

    mdl_t m1, m2;

    stopwatch_time_core #(.TICK_DIV(c_div), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .dir_down(dir_down), .load(load), .load_val(load_val),
        .sec_lo(sl1), .sec_hi(sh1), .min_lo(ml1), .min_hi(mh1),
        .running(run1), .tick(tick1), .wrap(wrap1), .done(done1), .load_err(lerr1)
    );

    stopwatch_time_core #(.TICK_DIV(c_div), .STEP(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .dir_down(dir_down), .load(load), .load_val(load_val),
        .sec_lo(sl2), .sec_hi(sh2), .min_lo(ml2), .min_hi(mh2),
        .running(run2), .tick(tick2), .wrap(wrap2), .done(done2), .load_err(lerr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit val_ok(input logic [15:0] v);
        return (v[3:0] <= 9) && (v[7:4] <= 5) && (v[11:8] <= 9) && (v[15:12] <= 5);
    endfunction

    function automatic int bcd_secs(input logic [15:0] v);
        return 600 * int'(v[15:12]) + 60 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    // Next model state from the time rules, using total seconds.
    function automatic mdl_t mdl_next(input mdl_t m, input int step);
        mdl_t n = m;
        n.tick = 0; n.wrap = 0; n.done = 0; n.lerr = 0;
        if (rst) begin
            n.secs = 0; n.st = 0; n.pres = 0;
        end else if (clear) begin
            n.secs = 0; n.st = 0; n.pres = 0;
        end else if (load) begin
            if (m.st != 1 && val_ok(load_val)) begin
                n.secs = bcd_secs(load_val);
                n.pres = 0;
            end else begin
                n.lerr = 1;
            end
        end else if (m.st == 1) begin
            if (stop) n.st = 2;
            else if (m.pres == c_div - 1) begin
                n.pres = 0;
                n.tick = 1;
                if (dir_down) begin
                    if (m.secs <= step) begin
                        n.secs = 0; n.done = 1; n.st = 0;
                    end else begin
                        n.secs = m.secs - step;
                    end
                end else begin
                    n.secs = m.secs + step;
                    if (n.secs >= 3600) begin
                        n.secs -= 3600;
                        n.wrap = 1;
                    end
                end
            end else begin
                n.pres = m.pres + 1;
            end
        end else if (start && !stop) begin
            n.st = 1;
        end
        return n;
    endfunction

    function automatic logic [20:0] exp_vec(input mdl_t m);
        return {4'(m.secs / 600), 4'((m.secs / 60) % 10), 4'((m.secs % 60) / 10),
                4'(m.secs % 10), (m.st == 1), m.tick, m.wrap, m.done, m.lerr};
    endfunction

    // One clock: the models step on the edge, and the outputs are sampled 1 ns later.
    task automatic clk1();
        @(posedge clk);
        m1 = mdl_next(m1, 1);
        m2 = mdl_next(m2, 2);
        #1;
        chk("model_step1", {mh1, ml1, sh1, sl1, run1, tick1, wrap1, done1, lerr1}, exp_vec(m1));
        chk("model_step2", {mh2, ml2, sh2, sl2, run2, tick2, wrap2, done2, lerr2}, exp_vec(m2));
    endtask

    task automatic idle_in();
        rst = 0; start = 0; stop = 0; clear = 0; load = 0;
    endtask

    task automatic run_n(input int n);
        idle_in();
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic pulse_start();
        idle_in(); start = 1; clk1(); idle_in();
    endtask

    task automatic pulse_stop();
        idle_in(); stop = 1; clk1(); idle_in();
    endtask

    task automatic pulse_load(input logic [15:0] v);
        idle_in(); load = 1; load_val = v; clk1(); idle_in();
    endtask

    initial begin
        m1 = '0; m2 = '0;
        rst = 1; start = 0; stop = 0; clear = 0; load = 0; dir_down = 0; load_val = '0;
        clk1(); clk1();
        chk("reset_digits", {mh1, ml1, sh1, sl1}, 16'h0000);
        chk("reset_flags", {run1, tick1, wrap1, done1, lerr1}, 5'b0);

        // First tick comes TICK_DIV cycles after start.
        pulse_start();
        chk("running_after_start", run1, 1'b1);
        run_n(3);
        chk("no_tick_early", tick1, 1'b0);
        run_n(1);
        chk("first_tick", tick1, 1'b1);
        chk("first_tick_sec_lo", sl1, 4'd1);
        chk("first_tick_step2", sl2, 4'd2);

        // Carry 00:59 -> 01:00.
        pulse_stop();
        pulse_load(16'h0059);
        pulse_start();
        run_n(4);
        chk("carry_0059", {mh1, ml1, sh1, sl1}, 16'h0100);
        chk("carry_0059_step2", {mh2, ml2, sh2, sl2}, 16'h0101);

        // Wrap 59:59 -> 00:00.
        pulse_stop();
        pulse_load(16'h5959);
        pulse_start();
        run_n(4);
        chk("wrap_value", {mh1, ml1, sh1, sl1}, 16'h0000);
        chk("wrap_pulse", wrap1, 1'b1);
        chk("wrap_still_running", run1, 1'b1);
        run_n(1);
        chk("wrap_one_cycle", wrap1, 1'b0);

        // Borrow 01:00 -> 00:59.
        pulse_stop();
        dir_down = 1;
        pulse_load(16'h0100);
        pulse_start();
        run_n(4);
        chk("borrow_0100", {mh1, ml1, sh1, sl1}, 16'h0059);
        chk("borrow_0100_step2", {mh2, ml2, sh2, sl2}, 16'h0058);

        // Count-down reaches zero. With STEP=2 the value clamps to zero.
        pulse_stop();
        pulse_load(16'h0001);
        pulse_start();
        run_n(4);
        chk("done_value", {mh1, ml1, sh1, sl1}, 16'h0000);
        chk("done_pulse", done1, 1'b1);
        chk("clamp_done_step2", {done2, mh2, ml2, sh2, sl2}, 17'h10000);
        run_n(1);
        chk("idle_after_done", run1, 1'b0);

        // STEP=2 up-count across the minute boundary.
        dir_down = 0;
        pulse_load(16'h0058);
        pulse_start();
        run_n(4);
        chk("step2_0058", {mh2, ml2, sh2, sl2}, 16'h0100);

        // Pause keeps the prescaler: tick after TICK_DIV-2 more RUN cycles.
        idle_in(); clear = 1; clk1();
        pulse_start();
        run_n(2);
        pulse_stop();
        run_n(10);
        pulse_start();
        run_n(1);
        chk("resume_no_tick", tick1, 1'b0);
        run_n(1);
        chk("resume_tick", tick1, 1'b1);

        // Rejected loads.
        pulse_load(16'h1234);
        chk("load_in_run_err", lerr1, 1'b1);
        chk("load_in_run_value", {mh1, ml1, sh1, sl1}, 16'h0001);
        pulse_stop();
        pulse_load(16'h6A00);
        chk("load_bad_err", lerr1, 1'b1);
        chk("load_bad_value", {mh1, ml1, sh1, sl1}, 16'h0001);

        // clear beats start.
        idle_in(); clear = 1; start = 1; clk1(); idle_in();
        chk("clear_start", {run1, mh1, ml1, sh1, sl1}, 17'h00000);

        // rst mid-count.
        pulse_start();
        run_n(5);
        idle_in(); rst = 1; clk1(); idle_in();
        chk("rst_mid_run", {mh1, ml1, sh1, sl1, run1, tick1, wrap1, done1, lerr1}, 21'd0);

        // Randomized traffic, checked against the models every cycle.
        for (int i = 0; i < 3000; i++) begin
            idle_in();
            rst   = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) dir_down = ~dir_down;
            if ($urandom_range(0, 3) == 0)
                load_val = 16'($urandom);
            else
                load_val = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)),
                            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            clk1();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
